// File: rtl/cpu_tracker_pkg.sv
// Shared constants for the CPU tracker performance counters:
// event channel assignments and default bank geometry.
package cpu_tracker_pkg;

  localparam int EVT_ICACHE_MISS     = 0;
  localparam int EVT_ICACHE_CONFLICT = 1;
  localparam int EVT_DCACHE_MISS     = 2;
  localparam int EVT_DCACHE_CONFLICT = 3;

  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 32;

endpackage

// File: rtl/perf_counter.sv
// Single live event counter with sticky overflow flag.
// Wraps to zero or holds at all-ones depending on SATURATE.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             ovf
);

  logic [CNT_W-1:0] count_reg;
  logic             ovf_reg;

  always_ff @(posedge CLK) begin
    if (RST || clear) begin
      count_reg <= '0;
      ovf_reg   <= 1'b0;
    end else if (inc) begin
      if (&count_reg) begin
        ovf_reg <= 1'b1;
        if (SATURATE == 0) begin
          count_reg <= '0;
        end
      end else begin
        count_reg <= count_reg + 1'b1;
      end
    end
  end

  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of N_CH event counters with a snapshot bank and a one-cycle
// registered read port selecting either live or snapshot values.
module perf_counter_bank
  import cpu_tracker_pkg::*;
#(
  parameter int N_CH     = DEF_N_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 0,
  localparam int IDX_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             en,
  input  logic [N_CH-1:0]  evt,
  input  logic             clear,
  input  logic             snap,
  input  logic             rd_req,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic             rd_snap,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic             rd_err,
  output logic [N_CH-1:0]  ovf
);

  localparam logic [IDX_W:0] CH_LIMIT = (IDX_W + 1)'(N_CH);

  logic [CNT_W-1:0] live [N_CH];
  logic [CNT_W-1:0] snap_reg [N_CH];

  logic             rd_valid_reg;
  logic [CNT_W-1:0] rd_data_reg;
  logic             rd_err_reg;
  logic             idx_oob;
  logic [CNT_W-1:0] sel_data;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    perf_counter #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_cnt (
      .CLK   (CLK),
      .RST   (RST),
      .inc   (en & evt[gi]),
      .clear (clear),
      .count (live[gi]),
      .ovf   (ovf[gi])
    );

    // Captures the pre-increment / pre-clear value of the live counter.
    always_ff @(posedge CLK) begin
      if (RST) begin
        snap_reg[gi] <= '0;
      end else if (snap) begin
        snap_reg[gi] <= live[gi];
      end
    end
  end

  assign idx_oob = ({1'b0, rd_idx} >= CH_LIMIT);

  always_comb begin
    sel_data = '0;
    if (!idx_oob) begin
      sel_data = rd_snap ? snap_reg[rd_idx] : live[rd_idx];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rd_valid_reg <= 1'b0;
      rd_data_reg  <= '0;
      rd_err_reg   <= 1'b0;
    end else begin
      rd_valid_reg <= rd_req;
      rd_err_reg   <= rd_req & idx_oob;
      if (rd_req) begin
        rd_data_reg <= sel_data;
      end
    end
  end

  assign rd_valid = rd_valid_reg;
  assign rd_data  = rd_data_reg;
  assign rd_err   = rd_err_reg;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Two counter banks (4ch wrapping, 3ch saturating, both 8-bit) driven with
// shared directed stimulus and checked against a behavioural scoreboard.
module tb_perf_counter_bank;

  logic       CLK = 1'b0;
  logic       RST, en, clear, snap, rd_req, rd_snap;
  logic [1:0] rd_idx;
  logic [3:0] evt;

  logic       a_rd_valid, a_rd_err;
  logic [7:0] a_rd_data;
  logic [3:0] a_ovf;
  logic       b_rd_valid, b_rd_err;
  logic [7:0] b_rd_data;
  logic [2:0] b_ovf;

  always #5 CLK = ~CLK;

  perf_counter_bank #(.N_CH(4), .CNT_W(8), .SATURATE(0)) dut_a (
    .CLK(CLK), .RST(RST), .en(en), .evt(evt), .clear(clear), .snap(snap),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_snap(rd_snap),
    .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err), .ovf(a_ovf)
  );

  perf_counter_bank #(.N_CH(3), .CNT_W(8), .SATURATE(1)) dut_b (
    .CLK(CLK), .RST(RST), .en(en), .evt(evt[2:0]), .clear(clear), .snap(snap),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_snap(rd_snap),
    .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err), .ovf(b_ovf)
  );

  typedef struct {
    bit         valid;
    logic [7:0] data;
    bit         err;
  } rd_exp_t;

  rd_exp_t qa[$];
  rd_exp_t qb[$];

  int         ma[4], sa[4], mb[3], sb[3];
  logic [3:0] oa;
  logic [2:0] ob;
  logic [7:0] last_a, last_b;
  int         n_checks = 0;
  int         n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic cycle(input bit rst_i, input bit en_i, input bit clr_i, input bit snp_i,
                       input bit req_i, input bit rs_i, input logic [1:0] idx_i,
                       input logic [3:0] evt_i);
    rd_exp_t ea, eb;
    RST = rst_i; en = en_i; clear = clr_i; snap = snp_i;
    rd_req = req_i; rd_snap = rs_i; rd_idx = idx_i; evt = evt_i;
    // expected read results use the state from before this edge
    if (rst_i) begin
      last_a = 8'd0; last_b = 8'd0;
      ea = '{valid: 1'b0, data: 8'd0, err: 1'b0};
      eb = '{valid: 1'b0, data: 8'd0, err: 1'b0};
    end else if (req_i) begin
      last_a = 8'(rs_i ? sa[idx_i] : ma[idx_i]);
      ea = '{valid: 1'b1, data: last_a, err: 1'b0};
      if (idx_i >= 2'd3) begin
        last_b = 8'd0;
        eb = '{valid: 1'b1, data: 8'd0, err: 1'b1};
      end else begin
        last_b = 8'(rs_i ? sb[idx_i] : mb[idx_i]);
        eb = '{valid: 1'b1, data: last_b, err: 1'b0};
      end
    end else begin
      ea = '{valid: 1'b0, data: last_a, err: 1'b0};
      eb = '{valid: 1'b0, data: last_b, err: 1'b0};
    end
    qa.push_back(ea);
    qb.push_back(eb);

    @(posedge CLK);
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin ma[i] = 0; sa[i] = 0; end
      for (int i = 0; i < 3; i++) begin mb[i] = 0; sb[i] = 0; end
      oa = '0; ob = '0;
    end else begin
      if (snp_i) begin
        for (int i = 0; i < 4; i++) sa[i] = ma[i];
        for (int i = 0; i < 3; i++) sb[i] = mb[i];
      end
      if (clr_i) begin
        for (int i = 0; i < 4; i++) ma[i] = 0;
        for (int i = 0; i < 3; i++) mb[i] = 0;
        oa = '0; ob = '0;
      end else if (en_i) begin
        for (int i = 0; i < 4; i++) begin
          if (evt_i[i]) begin
            if (ma[i] == 255) begin ma[i] = 0; oa[i] = 1'b1; end
            else ma[i] = ma[i] + 1;
          end
        end
        for (int i = 0; i < 3; i++) begin
          if (evt_i[i]) begin
            if (mb[i] == 255) ob[i] = 1'b1;
            else mb[i] = mb[i] + 1;
          end
        end
      end
    end

    #1;
    ea = qa.pop_front();
    eb = qb.pop_front();
    check("a_rd_valid", 64'(a_rd_valid), 64'(ea.valid));
    check("a_rd_data", 64'(a_rd_data), 64'(ea.data));
    if (ea.valid) check("a_rd_err", 64'(a_rd_err), 64'(ea.err));
    check("a_ovf", 64'(a_ovf), 64'(oa));
    check("b_rd_valid", 64'(b_rd_valid), 64'(eb.valid));
    check("b_rd_data", 64'(b_rd_data), 64'(eb.data));
    if (eb.valid) check("b_rd_err", 64'(b_rd_err), 64'(eb.err));
    check("b_ovf", 64'(b_ovf), 64'(ob));
    $display("cyc rst=%0b en=%0b clr=%0b snp=%0b req=%0b rs=%0b idx=%0d evt=%b | a v=%0b d=%0d e=%0b ovf=%b | b v=%0b d=%0d e=%0b ovf=%b",
             rst_i, en_i, clr_i, snp_i, req_i, rs_i, idx_i, evt_i,
             a_rd_valid, a_rd_data, a_rd_err, a_ovf, b_rd_valid, b_rd_data, b_rd_err, b_ovf);
  endtask

  initial begin
    RST = 1'b1; en = 1'b0; clear = 1'b0; snap = 1'b0;
    rd_req = 1'b0; rd_snap = 1'b0; rd_idx = 2'd0; evt = 4'd0;
    for (int i = 0; i < 4; i++) begin ma[i] = 0; sa[i] = 0; end
    for (int i = 0; i < 3; i++) begin mb[i] = 0; sb[i] = 0; end
    oa = '0; ob = '0; last_a = 8'd0; last_b = 8'd0;

    // reset with a read request in the same cycle: no valid afterwards
    cycle(1, 0, 0, 0, 1, 0, 2'd0, 4'b0000);
    cycle(0, 0, 0, 0, 1, 0, 2'd0, 4'b0000);

    // 257 events on channel 2: wrapping bank reads 1, saturating bank 255
    repeat (257) cycle(0, 1, 0, 0, 0, 0, 2'd0, 4'b0100);
    cycle(0, 1, 0, 0, 1, 0, 2'd2, 4'b0000);
    check("wrap257_data", 64'(a_rd_data), 64'd1);
    check("wrap257_ovf", 64'(a_ovf), 64'b0100);
    check("sat257_data", 64'(b_rd_data), 64'd255);

    // events with en low, then en high with no events
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 2'd0, 4'b1111);
    cycle(0, 1, 0, 0, 0, 0, 2'd0, 4'b0000);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 2'(i), 4'b0000);
    check("oob_data", 64'(b_rd_data), 64'd0);
    check("oob_err", 64'(b_rd_err), 64'd1);
    check("oob_valid", 64'(b_rd_valid), 64'd1);

    // 300 events on channel 0, then clear (with a lost event)
    repeat (300) cycle(0, 1, 0, 0, 0, 0, 2'd0, 4'b0001);
    cycle(0, 1, 0, 0, 1, 0, 2'd0, 4'b0000);
    check("sat300_data", 64'(b_rd_data), 64'd255);
    check("sat300_ovf0", 64'(b_ovf[0]), 64'd1);
    check("wrap300_data", 64'(a_rd_data), 64'd44);
    cycle(0, 1, 1, 0, 0, 0, 2'd0, 4'b0001);
    cycle(0, 1, 0, 0, 1, 0, 2'd0, 4'b0000);
    check("clr_data", 64'(b_rd_data), 64'd0);
    check("clr_ovf", 64'(b_ovf), 64'd0);

    // snap + clear + event on channel 1 at count 10
    repeat (10) cycle(0, 1, 0, 0, 0, 0, 2'd0, 4'b0010);
    cycle(0, 1, 1, 1, 0, 0, 2'd0, 4'b0010);
    cycle(0, 1, 0, 0, 1, 1, 2'd1, 4'b0000);
    check("snapclr_snap", 64'(a_rd_data), 64'd10);
    cycle(0, 1, 0, 0, 1, 0, 2'd1, 4'b0000);
    check("snapclr_live", 64'(a_rd_data), 64'd0);

    // mixed traffic
    for (int n = 0; n < 200; n++) begin
      cycle(0, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)));
    end

    // consecutive snapshots while reading the snapshot bank
    repeat (4) cycle(0, 1, 0, 1, 1, 1, 2'd1, 4'b1111);

    // back-to-back reads at idx 0,1,3
    cycle(0, 1, 0, 0, 1, 0, 2'd0, 4'b0000);
    cycle(0, 1, 0, 0, 1, 0, 2'd1, 4'b0000);
    cycle(0, 1, 0, 0, 1, 0, 2'd3, 4'b0000);
    cycle(0, 1, 0, 0, 0, 0, 2'd0, 4'b0000);

    // reset overriding everything with a read in flight
    cycle(0, 1, 0, 1, 1, 0, 2'd1, 4'b1111);
    cycle(1, 1, 1, 1, 1, 0, 2'd1, 4'b1111);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 0, 2'(i), 4'b0000);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 1, 2'(i), 4'b0000);
    // first edge after reset counts
    cycle(0, 1, 0, 0, 0, 0, 2'd0, 4'b1111);
    cycle(0, 0, 0, 0, 1, 0, 2'd3, 4'b0000);
    check("post_rst_cnt", 64'(a_rd_data), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
